// File: rtl/spi_adc_pkg.sv
// Shared types and constants for the SPI ADC scan master: FSM states,
// default parameter values and a constant-width helper.
package spi_adc_pkg;

   localparam int DEF_CLK_DIV    = 4;
   localparam int DEF_FRAME_BITS = 16;
   localparam int DEF_LEAD_BITS  = 3;
   localparam int DEF_DATA_W     = 8;
   localparam int DEF_N_CH       = 2;
   localparam int DEF_CH_W       = 1;
   localparam int DEF_QUIET_CYC  = 2;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SELECT,
      ST_SHIFT,
      ST_DONE,
      ST_QUIET
   } state_t;

   // Ceiling log2 with a floor of 1 so it can size any counter or index.
   function automatic int clog2(input int v);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < v) r = i + 1;
      end
      if (r < 1) r = 1;
      return r;
   endfunction

endpackage

// File: rtl/spi_sclk_gen.sv
// SPI clock divider: while enabled, sclk is low for CLK_DIV cycles then high
// for CLK_DIV cycles; rise/fall strobe on the clk edge where sclk changes.
module spi_sclk_gen
   import spi_adc_pkg::*;
#(
   parameter int CLK_DIV = DEF_CLK_DIV
) (
   input  logic clk,
   input  logic n_rst,
   input  logic en,
   output logic sclk,
   output logic rise,
   output logic fall
);

   localparam int CW = clog2(CLK_DIV + 1);

   logic [CW-1:0] cnt;
   logic          phase;
   logic          half_end;

   assign half_end = (cnt == CW'(CLK_DIV - 1));

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         cnt   <= '0;
         phase <= 1'b0;
      end else if (!en) begin
         cnt   <= '0;
         phase <= 1'b0;
      end else if (half_end) begin
         cnt   <= '0;
         phase <= ~phase;
      end else begin
         cnt   <= cnt + 1'b1;
      end
   end

   // Disabled clock idles high; enabled clock starts in its low half.
   assign sclk = ~en | phase;
   assign rise = en & ~phase & half_end;
   assign fall = en & phase & half_end;

endmodule

// File: rtl/spi_adc_scan_master.sv
// Read-only SPI master scanning up to N_CH serial ADCs, one cs_n each,
// returning each captured sample with its channel tag.
module spi_adc_scan_master
   import spi_adc_pkg::*;
#(
   parameter int CLK_DIV    = DEF_CLK_DIV,
   parameter int FRAME_BITS = DEF_FRAME_BITS,
   parameter int LEAD_BITS  = DEF_LEAD_BITS,
   parameter int DATA_W     = DEF_DATA_W,
   parameter int N_CH       = DEF_N_CH,
   parameter int CH_W       = DEF_CH_W,
   parameter int QUIET_CYC  = DEF_QUIET_CYC
) (
   input  logic              clk,
   input  logic              n_rst,
   input  logic              start,
   input  logic              stop,
   input  logic              cont,
   input  logic [N_CH-1:0]   ch_mask,
   output logic              sclk,
   output logic [N_CH-1:0]   cs_n,
   input  logic              sdata,
   output logic              busy,
   output logic              data_valid,
   output logic [DATA_W-1:0] data,
   output logic [CH_W-1:0]   data_ch,
   output logic              led,
   output state_t            dbg_state
);

   // Control semantics: start is a one-cycle request honoured only in IDLE
   // with a non-zero ch_mask; stop is a level sampled every cycle and beats
   // start; data_valid is a one-cycle pulse with no back-pressure.

   localparam int BW   = clog2(FRAME_BITS + 1);
   localparam int TMAX = (CLK_DIV > QUIET_CYC) ? CLK_DIV : QUIET_CYC;
   localparam int TW   = clog2(TMAX + 1);

   state_t            state, state_d;
   logic [CH_W-1:0]   ch, ch_d;
   logic [N_CH-1:0]   mask_q, mask_d;
   logic              abort_q, abort_d;
   logic [TW-1:0]     tmr;
   logic [BW-1:0]     bit_cnt;
   logic [DATA_W-1:0] shreg;
   logic [CH_W-1:0]   low_ch, nxt_ch;
   logic              nxt_found;
   logic              sclk_en, rise, fall;
   logic              sel_end, quiet_end, frame_end, load_out;

   spi_sclk_gen #(.CLK_DIV(CLK_DIV)) u_sclk_gen (
      .clk   (clk),
      .n_rst (n_rst),
      .en    (sclk_en),
      .sclk  (sclk),
      .rise  (rise),
      .fall  (fall)
   );

   assign sclk_en   = (state == ST_SHIFT);
   assign sel_end   = (tmr == TW'(CLK_DIV - 1));
   assign quiet_end = (tmr == TW'(QUIET_CYC - 1));
   assign frame_end = fall && (bit_cnt == BW'(FRAME_BITS));
   assign load_out  = (state == ST_SHIFT) && (state_d == ST_DONE);

   // Lowest enabled channel of the live mask, and next enabled channel above ch.
   always_comb begin
      low_ch    = '0;
      nxt_ch    = '0;
      nxt_found = 1'b0;
      for (int i = N_CH - 1; i >= 0; i--) begin
         if (ch_mask[i]) low_ch = CH_W'(i);
         if (mask_q[i] && (i > int'(ch))) begin
            nxt_ch    = CH_W'(i);
            nxt_found = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state   <= ST_IDLE;
         ch      <= '0;
         mask_q  <= '0;
         abort_q <= 1'b0;
      end else begin
         state   <= state_d;
         ch      <= ch_d;
         mask_q  <= mask_d;
         abort_q <= abort_d;
      end
   end

   always_comb begin
      state_d = state;
      ch_d    = ch;
      mask_d  = mask_q;
      abort_d = abort_q;
      case (state)
         ST_IDLE: begin
            abort_d = 1'b0;
            if (!stop && start && (|ch_mask)) begin
               mask_d  = ch_mask;
               ch_d    = low_ch;
               state_d = ST_SELECT;
            end
         end
         ST_SELECT: if (sel_end) state_d = ST_SHIFT;
         ST_SHIFT:  if (frame_end) state_d = ST_DONE;
         ST_DONE:   state_d = ST_QUIET;
         ST_QUIET: begin
            if (quiet_end) begin
               if (abort_q) begin
                  state_d = ST_IDLE;
               end else if (nxt_found) begin
                  ch_d    = nxt_ch;
                  state_d = ST_SELECT;
               end else if (cont && (|ch_mask)) begin
                  mask_d  = ch_mask;
                  ch_d    = low_ch;
                  state_d = ST_SELECT;
               end else begin
                  state_d = ST_IDLE;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
      // Abort drops the select at once and still honours the quiet gap.
      if (stop && (state != ST_IDLE)) begin
         state_d = ST_QUIET;
         abort_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         tmr     <= '0;
         bit_cnt <= '0;
         shreg   <= '0;
         data    <= '0;
         data_ch <= '0;
         led     <= 1'b0;
      end else begin
         if ((state == ST_IDLE) || (state_d != state) || stop) tmr <= '0;
         else                                                  tmr <= tmr + 1'b1;

         if (state != ST_SHIFT) bit_cnt <= '0;
         else if (rise)         bit_cnt <= bit_cnt + 1'b1;

         // bit_cnt is the 0-based frame index of the bit sampled on this rise.
         if ((state == ST_SHIFT) && rise && (bit_cnt >= BW'(LEAD_BITS)) &&
             (bit_cnt < BW'(LEAD_BITS + DATA_W)))
            shreg <= DATA_W'({shreg, sdata});

         if (load_out) begin
            data    <= shreg;
            data_ch <= ch;
            led     <= ~led;
         end
      end
   end

   always_comb begin
      cs_n = '1;
      if ((state == ST_SELECT) || (state == ST_SHIFT)) cs_n[ch] = 1'b0;
   end

   assign busy       = (state != ST_IDLE);
   assign data_valid = (state == ST_DONE);
   assign dbg_state  = state;

endmodule

// File: tb/tb_spi_adc_scan_master.sv
// Directed bench for spi_adc_scan_master: an ADC model drives sdata and a
// schedule-based model predicts every data_valid cycle, sample and tag.
module tb_spi_adc_scan_master;
   import spi_adc_pkg::*;

   localparam int CLK_DIV    = 4;
   localparam int FRAME_BITS = 16;
   localparam int LEAD_BITS  = 3;
   localparam int DATA_W     = 8;
   localparam int N_CH       = 2;
   localparam int CH_W       = 1;
   localparam int QUIET_CYC  = 2;
   localparam int DONE_OFS   = CLK_DIV + 2 * CLK_DIV * FRAME_BITS + 1;
   localparam int PERIOD     = DONE_OFS + QUIET_CYC;
   localparam int W          = CH_W + DATA_W;

   logic              clk = 1'b0;
   logic              n_rst = 1'b0;
   logic              start = 1'b0;
   logic              stop = 1'b0;
   logic              cont = 1'b0;
   logic              sdata = 1'b0;
   logic [N_CH-1:0]   ch_mask = '0;
   logic              sclk;
   logic [N_CH-1:0]   cs_n;
   logic              busy;
   logic              data_valid;
   logic [DATA_W-1:0] data;
   logic [CH_W-1:0]   data_ch;
   logic              led;
   state_t            dbg_state;

   spi_adc_scan_master #(
      .CLK_DIV(CLK_DIV), .FRAME_BITS(FRAME_BITS), .LEAD_BITS(LEAD_BITS),
      .DATA_W(DATA_W), .N_CH(N_CH), .CH_W(CH_W), .QUIET_CYC(QUIET_CYC)
   ) dut (
      .clk(clk), .n_rst(n_rst), .start(start), .stop(stop), .cont(cont),
      .ch_mask(ch_mask), .sclk(sclk), .cs_n(cs_n), .sdata(sdata),
      .busy(busy), .data_valid(data_valid), .data(data), .data_ch(data_ch),
      .led(led), .dbg_state(dbg_state)
   );

   // clock / reset
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int                n_checks = 0;
   int                n_fail = 0;
   logic [W-1:0]      exp_q[$];
   int                exp_cyc[$];
   logic              led_m;
   logic [DATA_W-1:0] adc_val [N_CH];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // ADC model: presents frame bit k, advancing after each sclk rise.
   initial begin : adc_model
      int k;
      int c;
      logic prev;
      logic [FRAME_BITS-1:0] w;
      k = 0;
      prev = 1'b1;
      forever begin
         @(posedge clk);
         #2;
         if (&cs_n) begin
            k = 0;
            sdata = 1'b0;
         end else begin
            c = 0;
            for (int i = 0; i < N_CH; i++) if (!cs_n[i]) c = i;
            if (!prev && sclk) k++;
            w = FRAME_BITS'(adc_val[c]) << (FRAME_BITS - LEAD_BITS - DATA_W);
            sdata = (k < FRAME_BITS) ? w[FRAME_BITS-1-k] : 1'b0;
         end
         prev = sclk;
      end
   end

   // scoreboard: every cycle, data_valid/data/tag/led against the schedule
   initial begin : compare
      logic hit;
      led_m = 1'b0;
      forever begin
         @(negedge clk);
         if (!n_rst) begin
            led_m = 1'b0;
            exp_q.delete();
            exp_cyc.delete();
         end else begin
            hit = (exp_cyc.size() > 0) && (exp_cyc[0] == cyc);
            check("data_valid", data_valid, hit);
            if (hit) begin
               led_m = ~led_m;
               check("sample", {data_ch, data}, exp_q[0]);
               void'(exp_q.pop_front());
               void'(exp_cyc.pop_front());
            end
            check("led", led, led_m);
            check("cs_onehot", ($countones(~cs_n) <= 1), 1);
         end
      end
   end

   initial begin : watchdog
      #1000000;
      $display("FAIL watchdog: simulation did not finish at cycle %0d", cyc);
      $fatal(1);
   end

   // driver tasks
   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic wait_until(input int t);
      if (cyc > t) begin
         n_checks++;
         n_fail++;
         $display("FAIL wait_until: at cycle %0d past target %0d", cyc, t);
      end
      while (cyc < t) @(negedge clk);
   endtask

   task automatic do_start(input logic [N_CH-1:0] m);
      ch_mask = m;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic expect_frame(input int t, input int ch, input int k);
      exp_cyc.push_back(t + DONE_OFS + PERIOD * k);
      exp_q.push_back({CH_W'(ch), adc_val[ch]});
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_sclk"}, sclk, 1);
      check({tag, "_cs_n"}, cs_n, 2'b11);
      check({tag, "_busy"}, busy, 0);
      check({tag, "_valid"}, data_valid, 0);
      check({tag, "_data"}, data, 0);
      check({tag, "_data_ch"}, data_ch, 0);
      check({tag, "_led"}, led, 0);
      check({tag, "_state"}, dbg_state, ST_IDLE);
   endtask

   initial begin : main
      int t;
      adc_val[0] = 8'h00;
      adc_val[1] = 8'h00;
      tick(3);
      check_reset_outputs("reset");
      n_rst = 1'b1;
      tick(2);

      // 1: single channel 0, one-shot
      adc_val[0] = 8'hA5;
      t = cyc;
      expect_frame(t, 0, 0);
      do_start(2'b01);
      for (int i = t + 1; i <= t + 132; i++) begin
         wait_until(i);
         check("t1_cs_n_sel", cs_n, 2'b10);
      end
      wait_until(t + 133);
      check("t1_valid", data_valid, 1);
      check("t1_data", data, 8'hA5);
      check("t1_ch", data_ch, 0);
      check("t1_led", led, 1);
      check("t1_cs_n_done", cs_n, 2'b11);
      wait_until(t + 135);
      check("t1_busy_quiet", busy, 1);
      wait_until(t + 136);
      check("t1_busy_end", busy, 0);
      tick(3);

      // 2: both channels, one-shot
      adc_val[0] = 8'h3C;
      adc_val[1] = 8'hC3;
      t = cyc;
      expect_frame(t, 0, 0);
      expect_frame(t, 1, 1);
      do_start(2'b11);
      wait_until(t + 133);
      check("t2_data0", data, 8'h3C);
      check("t2_ch0", data_ch, 0);
      wait_until(t + 268);
      check("t2_data1", data, 8'hC3);
      check("t2_ch1", data_ch, 1);
      wait_until(t + 270);
      check("t2_busy_quiet", busy, 1);
      wait_until(t + 271);
      check("t2_busy_end", busy, 0);
      tick(3);

      // 3: continuous on channel 1, cont dropped mid fourth frame
      adc_val[1] = 8'h5A;
      cont = 1'b1;
      t = cyc;
      for (int k = 0; k < 4; k++) expect_frame(t, 1, k);
      do_start(2'b10);
      wait_until(t + PERIOD * 3 + 60);
      cont = 1'b0;
      wait_until(t + 538);
      check("t3_last_valid", data_valid, 1);
      check("t3_last_data", data, 8'h5A);
      wait_until(t + 541);
      check("t3_busy_end", busy, 0);
      tick(PERIOD + 10);
      check("t3_no_extra", exp_cyc.size(), 0);

      // 4: stop on the 8th sclk rise
      adc_val[0] = 8'hFF;
      t = cyc;
      do_start(2'b01);
      wait_until(t + 64);
      check("t4_sclk_low_before_rise", sclk, 0);
      stop = 1'b1;
      tick(1);
      stop = 1'b0;
      check("t4_cs_n", cs_n, 2'b11);
      check("t4_sclk", sclk, 1);
      check("t4_busy_q1", busy, 1);
      wait_until(t + 66);
      check("t4_busy_q2", busy, 1);
      wait_until(t + 67);
      check("t4_busy_end", busy, 0);
      tick(PERIOD);

      // 5: ignored starts
      do_start(2'b00);
      check("t5_mask0_busy", busy, 0);
      tick(3);
      check("t5_mask0_busy_later", busy, 0);
      ch_mask = 2'b01;
      start = 1'b1;
      stop = 1'b1;
      tick(1);
      start = 1'b0;
      stop = 1'b0;
      check("t5_stop_wins", busy, 0);
      adc_val[0] = 8'h77;
      t = cyc;
      expect_frame(t, 0, 0);
      do_start(2'b01);
      wait_until(t + 50);
      do_start(2'b11);
      wait_until(t + 136);
      check("t5_busy_end", busy, 0);
      tick(10);
      check("t5_one_frame", exp_cyc.size(), 0);

      // 6: async reset mid-shift, then a clean frame
      adc_val[0] = 8'h96;
      t = cyc;
      expect_frame(t, 0, 0);
      do_start(2'b01);
      wait_until(t + 70);
      n_rst = 1'b0;
      #1;
      check_reset_outputs("t6_rst");
      tick(3);
      n_rst = 1'b1;
      tick(2);
      t = cyc;
      expect_frame(t, 0, 0);
      do_start(2'b01);
      wait_until(t + 133);
      check("t6_data", data, 8'h96);
      check("t6_led", led, 1);
      wait_until(t + 136);
      check("t6_busy_end", busy, 0);
      tick(5);
      check("final_queue_empty", exp_cyc.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
